// File: rtl/drive_sequencer_if.sv
// Command bus between the Nios command PIOs and the drive sequencer.
// Handshake: a command transfers on every clock edge where cmd_valid and cmd_ready are both high; payload is sampled only on that edge.
interface drive_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [6:0]  cmd_speed;
  logic        cmd_reverse;
  logic [15:0] cmd_dist_cm;

  modport master (output cmd_valid, cmd_speed, cmd_reverse, cmd_dist_cm, input cmd_ready);
  modport slave  (input cmd_valid, cmd_speed, cmd_reverse, cmd_dist_cm, output cmd_ready);
endinterface

// File: rtl/drive_sequencer.sv
// Ramp-limited motion sequencer with light/obstacle speed ceilings and braked direction reversal.
// Optional ESTOP_EN: red/obstacle force drive_speed to 0 on the next cycle instead of ramping down.
module drive_sequencer #(
  parameter int unsigned RAMP_DIV   = 50000,
  parameter int unsigned YELLOW_PCT = 30,
  parameter int unsigned STOP_CM    = 20,
  parameter int unsigned DIR_WAIT   = 1000
) (
  input  logic               clk_clk,
  input  logic               reset_reset,
  drive_sequencer_if.slave   cmd,
  input  logic               greenlight,
  input  logic               yellowlight,
  input  logic               redlight,
  input  logic [8:0]         flsensor_cm,
  input  logic [8:0]         frsensor_cm,
  input  logic [31:0]        encoder_cm,
  output logic [6:0]         drive_speed,
  output logic               reverse,
  output logic               encoder_reset,
  output logic               done,
  output logic [2:0]         state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_BRAKE  = 3'd3;
  localparam logic [2:0] S_DWELL  = 3'd4;

  localparam int RW = $clog2(RAMP_DIV + 1);
  localparam int DW = $clog2(DIR_WAIT + 1);

`ifdef ESTOP_EN
  localparam bit ESTOP = 1'b1;
`else
  localparam bit ESTOP = 1'b0;
`endif

  logic [RW-1:0] ramp_cnt;
  logic          ramp_tick;
  logic [DW-1:0] dwell_cnt;
  logic [1:0]    red_sync, yel_sync, grn_sync;
  logic [6:0]    lat_speed;
  logic          lat_reverse;
  logic [15:0]   lat_dist;
  logic          flip_pending;
  logic          run_first;
  logic [8:0]    min_cm;
  logic          red_eff, yel_eff, obstacle, stop_cond;
  logic [6:0]    ceiling, target, clamped;
  logic          accept, dist_hit;

  assign cmd.cmd_ready = (state == S_IDLE) || (state == S_RUN);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;
  assign clamped       = (cmd.cmd_speed > 7'd100) ? 7'd100 : cmd.cmd_speed;
  assign ramp_tick     = (ramp_cnt == RW'(RAMP_DIV - 1));
  // Encoder may still show the previous move's distance right after ACCEPT.
  assign dist_hit      = ~run_first && (lat_dist != 16'd0) && (encoder_cm >= {16'd0, lat_dist});

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      red_sync <= 2'b00;
      yel_sync <= 2'b00;
      grn_sync <= 2'b00;
    end else begin
      red_sync <= {red_sync[0], redlight};
      yel_sync <= {yel_sync[0], yellowlight};
      grn_sync <= {grn_sync[0], greenlight};
    end
  end

  // Green only masks red/yellow; it never raises the ceiling by itself.
  always_comb begin
    min_cm    = (flsensor_cm < frsensor_cm) ? flsensor_cm : frsensor_cm;
    red_eff   = red_sync[1] & ~grn_sync[1];
    yel_eff   = yel_sync[1] & ~grn_sync[1];
    obstacle  = ~reverse & ({1'b0, min_cm} < 10'(STOP_CM));
    stop_cond = red_eff | obstacle;
    if (stop_cond)
      ceiling = 7'd0;
    else if (yel_eff && (lat_speed > 7'(YELLOW_PCT)))
      ceiling = 7'(YELLOW_PCT);
    else
      ceiling = lat_speed;
    target = ((state == S_ACCEPT) || (state == S_RUN)) ? ceiling : 7'd0;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)
      ramp_cnt <= '0;
    else if (ramp_tick)
      ramp_cnt <= '0;
    else
      ramp_cnt <= ramp_cnt + 1'b1;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset)
      drive_speed <= 7'd0;
    else if (ESTOP && stop_cond)
      drive_speed <= 7'd0;
    else if (ramp_tick && (drive_speed != target))
      drive_speed <= (drive_speed < target) ? drive_speed + 7'd1 : drive_speed - 7'd1;
  end

  // reverse only moves on entry to ACCEPT, which is always reached at zero speed or with unchanged direction.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state         <= S_IDLE;
      reverse       <= 1'b0;
      encoder_reset <= 1'b0;
      done          <= 1'b0;
      lat_speed     <= 7'd0;
      lat_reverse   <= 1'b0;
      lat_dist      <= 16'd0;
      flip_pending  <= 1'b0;
      run_first     <= 1'b0;
      dwell_cnt     <= '0;
    end else begin
      encoder_reset <= 1'b0;
      done          <= 1'b0;
      if (accept) begin
        lat_speed   <= clamped;
        lat_reverse <= cmd.cmd_reverse;
        lat_dist    <= cmd.cmd_dist_cm;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            state         <= S_ACCEPT;
            reverse       <= cmd.cmd_reverse;
            encoder_reset <= 1'b1;
          end
        end
        S_ACCEPT: begin
          state     <= S_RUN;
          run_first <= 1'b1;
        end
        S_RUN: begin
          run_first <= 1'b0;
          if (accept) begin
            if (cmd.cmd_reverse == reverse) begin
              state         <= S_ACCEPT;
              encoder_reset <= 1'b1;
            end else begin
              state        <= S_BRAKE;
              flip_pending <= 1'b1;
            end
          end else if (dist_hit) begin
            state        <= S_BRAKE;
            flip_pending <= 1'b0;
          end
        end
        S_BRAKE: begin
          if (drive_speed == 7'd0) begin
            state     <= S_DWELL;
            dwell_cnt <= '0;
          end
        end
        S_DWELL: begin
          if (dwell_cnt == DW'(DIR_WAIT - 1)) begin
            if (flip_pending) begin
              state         <= S_ACCEPT;
              reverse       <= lat_reverse;
              encoder_reset <= 1'b1;
            end else begin
              state <= S_IDLE;
              done  <= 1'b1;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drive_sequencer.sv
// Randomized bench for drive_sequencer against a cycle-level behavioural model.
// Honours ESTOP_EN the same way as the design.
`timescale 1ns/1ps
module tb_drive_sequencer;
  localparam int RAMP_DIV   = 4;
  localparam int YELLOW_PCT = 30;
  localparam int STOP_CM    = 20;
  localparam int DIR_WAIT   = 8;
  localparam int W          = 14;

`ifdef ESTOP_EN
  localparam bit ESTOP = 1'b1;
`else
  localparam bit ESTOP = 1'b0;
`endif

  // clock / reset
  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        greenlight, yellowlight, redlight;
  logic [8:0]  flsensor_cm, frsensor_cm;
  logic [31:0] encoder_cm;
  logic [6:0]  drive_speed;
  logic        reverse, encoder_reset, done;
  logic [2:0]  state;

  drive_sequencer_if cmd();

  drive_sequencer #(
    .RAMP_DIV(RAMP_DIV), .YELLOW_PCT(YELLOW_PCT), .STOP_CM(STOP_CM), .DIR_WAIT(DIR_WAIT)
  ) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .cmd(cmd),
    .greenlight(greenlight), .yellowlight(yellowlight), .redlight(redlight),
    .flsensor_cm(flsensor_cm), .frsensor_cm(frsensor_cm), .encoder_cm(encoder_cm),
    .drive_speed(drive_speed), .reverse(reverse), .encoder_reset(encoder_reset),
    .done(done), .state(state)
  );

  always #5 clk_clk = ~clk_clk;

  // scoreboard
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // behavioural model: phase codes are the documented state codes
  int n, m_phase, m_speed, m_rev, m_enc_rst, m_done;
  int m_lat_speed, m_lat_rev, m_lat_dist, m_flip, m_dwell_left, m_just;
  int red_d1, red_d2, yel_d1, yel_d2, grn_d1, grn_d2;
  int enc;

  task automatic model_reset();
    n = 0; m_phase = 0; m_speed = 0; m_rev = 0; m_enc_rst = 0; m_done = 0;
    m_lat_speed = 0; m_lat_rev = 0; m_lat_dist = 0; m_flip = 0; m_dwell_left = 0; m_just = 0;
    red_d1 = 0; red_d2 = 0; yel_d1 = 0; yel_d2 = 0; grn_d1 = 0; grn_d2 = 0;
  endtask

  task automatic model_step();
    int red_u, yel_u, mn, stop, ceil_v, target, new_speed, hs;
    red_u  = red_d2 & ~grn_d2;
    yel_u  = yel_d2 & ~grn_d2;
    mn     = (int'(flsensor_cm) < int'(frsensor_cm)) ? int'(flsensor_cm) : int'(frsensor_cm);
    stop   = (red_u != 0) || (m_rev == 0 && mn < STOP_CM);
    if (stop) ceil_v = 0;
    else if (yel_u != 0) ceil_v = (m_lat_speed < YELLOW_PCT) ? m_lat_speed : YELLOW_PCT;
    else ceil_v = m_lat_speed;
    target = (m_phase == 1 || m_phase == 2) ? ceil_v : 0;
    new_speed = m_speed;
    if (ESTOP && stop) new_speed = 0;
    else if ((n % RAMP_DIV) == RAMP_DIV - 1) begin
      if (target > m_speed) new_speed = m_speed + 1;
      else if (target < m_speed) new_speed = m_speed - 1;
    end
    hs = cmd.cmd_valid && (m_phase == 0 || m_phase == 2);
    m_enc_rst = 0;
    m_done = 0;
    case (m_phase)
      0: if (hs) begin m_phase = 1; m_rev = cmd.cmd_reverse; m_enc_rst = 1; end
      1: begin m_phase = 2; m_just = 1; end
      2: begin
        if (hs) begin
          if (int'(cmd.cmd_reverse) == m_rev) begin m_phase = 1; m_enc_rst = 1; end
          else begin m_phase = 3; m_flip = 1; end
        end else if (!m_just && m_lat_dist != 0 && enc >= m_lat_dist) begin
          m_phase = 3; m_flip = 0;
        end
        m_just = 0;
      end
      3: if (m_speed == 0) begin m_phase = 4; m_dwell_left = DIR_WAIT; end
      default: begin
        m_dwell_left--;
        if (m_dwell_left == 0) begin
          if (m_flip) begin m_phase = 1; m_rev = m_lat_rev; m_enc_rst = 1; end
          else begin m_phase = 0; m_done = 1; end
        end
      end
    endcase
    if (hs) begin
      m_lat_speed = (cmd.cmd_speed > 7'd100) ? 100 : int'(cmd.cmd_speed);
      m_lat_rev   = cmd.cmd_reverse;
      m_lat_dist  = cmd.cmd_dist_cm;
    end
    m_speed = new_speed;
    red_d2 = red_d1; red_d1 = redlight;
    yel_d2 = yel_d1; yel_d1 = yellowlight;
    grn_d2 = grn_d1; grn_d1 = greenlight;
    n++;
    exp_q.push_back({3'(m_phase), 7'(m_speed), m_rev[0], m_enc_rst[0], m_done[0],
                     (m_phase == 0 || m_phase == 2) ? 1'b1 : 1'b0});
  endtask

  // driver tasks
  int light_mode, obst;
  task automatic drive_inputs();
    cmd.cmd_valid = 1'b0;
    if ($urandom_range(0, 119) == 0) begin
      cmd.cmd_valid   = 1'b1;
      cmd.cmd_speed   = ($urandom_range(0, 4) == 0) ? 7'($urandom_range(0, 1) * 127) : 7'($urandom_range(1, 110));
      cmd.cmd_reverse = 1'($urandom_range(0, 1));
      cmd.cmd_dist_cm = ($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(1, 40));
    end
    if ($urandom_range(0, 59) == 0) begin
      redlight    = (light_mode == 2 || light_mode == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      yellowlight = (light_mode == 1 || light_mode == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      greenlight  = (light_mode >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if ($urandom_range(0, 79) == 0) obst = ~obst & 1;
    flsensor_cm = 9'($urandom_range(STOP_CM, 511));
    frsensor_cm = 9'($urandom_range(STOP_CM, 511));
    if (obst != 0) begin
      if ($urandom_range(0, 1) == 0) flsensor_cm = 9'($urandom_range(0, STOP_CM - 1));
      else frsensor_cm = 9'($urandom_range(0, STOP_CM - 1));
    end
    if (m_enc_rst != 0) enc = 0;
    else if (m_speed > 0 && $urandom_range(0, 3) == 0) enc++;
    encoder_cm = 32'(enc);
  endtask

  int prev_rev, prev_speed;
  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check_val("exp_q_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_val("state", 32'(state), 32'(e[13:11]));
    check_val("drive_speed", 32'(drive_speed), 32'(e[10:4]));
    check_val("reverse", 32'(reverse), 32'(e[3]));
    check_val("encoder_reset", 32'(encoder_reset), 32'(e[2]));
    check_val("done", 32'(done), 32'(e[1]));
    check_val("cmd_ready", 32'(cmd.cmd_ready), 32'(e[0]));
    if (int'(reverse) != prev_rev) check_val("rev_change_speed", 32'(prev_speed), 32'd0);
    prev_rev = reverse;
    prev_speed = drive_speed;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_state"}, 32'(state), 32'd0);
    check_val({tag, "_speed"}, 32'(drive_speed), 32'd0);
    check_val({tag, "_reverse"}, 32'(reverse), 32'd0);
    check_val({tag, "_enc_rst"}, 32'(encoder_reset), 32'd0);
    check_val({tag, "_done"}, 32'(done), 32'd0);
    check_val({tag, "_ready"}, 32'(cmd.cmd_ready), 32'd1);
  endtask

  task automatic async_reset();
    #2 reset_reset = 1'b1;
    #1 check_reset_values("mid_rst");
    @(negedge clk_clk);
    reset_reset = 1'b0;
    model_reset();
    exp_q.delete();
    enc = 0;
    prev_rev = 0;
    prev_speed = 0;
  endtask

  initial begin
    int did_reset;
    reset_reset = 1'b1;
    cmd.cmd_valid = 1'b0; cmd.cmd_speed = 7'd0; cmd.cmd_reverse = 1'b0; cmd.cmd_dist_cm = 16'd0;
    greenlight = 1'b0; yellowlight = 1'b0; redlight = 1'b0;
    flsensor_cm = 9'd300; frsensor_cm = 9'd300; encoder_cm = 32'd0;
    enc = 0; obst = 0; light_mode = 0; prev_rev = 0; prev_speed = 0;
    model_reset();
    repeat (3) @(negedge clk_clk);
    reset_reset = 1'b0;
    check_reset_values("rst");

    for (int seg = 0; seg < 12; seg++) begin
      light_mode = $urandom_range(0, 4);
      did_reset = 0;
      for (int c = 0; c < 500; c++) begin
        drive_inputs();
        model_step();
        @(negedge clk_clk);
        compare_outputs();
        if ((seg == 4 || seg == 9) && !did_reset &&
            ((c > 50 && m_phase == 3 && m_speed > 0) || c == 499)) begin
          did_reset = 1;
          async_reset();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/drive_sequencer.md
Name: drive_sequencer

Overview:
- Hardware motion sequencer between the Nios command PIOs and the drive motor interface.
- Accepts speed, direction and distance commands and ramp-limits the output speed.
- Enforces traffic-light and front-obstacle speed ceilings.
- Sequences direction reversal through a brake/dwell phase and resets the wheel encoder at each move start.

Parameters:
RAMP_DIV, 50000, clock cycles per 1% speed step (min 1)
YELLOW_PCT, 30, speed ceiling (%) while yellow light asserted
STOP_CM, 20, front obstacle threshold in cm
DIR_WAIT, 1000, zero-speed dwell cycles before a direction flip or completion

Ports:
clk_clk  in  1  system clock
reset_reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command strobe; accepted when cmd_valid & cmd_ready
cmd_ready  out  1  command can be accepted
cmd_speed  in  7  requested speed %, values >100 clamped to 100
cmd_reverse  in  1  requested direction, 1 = reverse
cmd_dist_cm  in  16  move distance in cm; 0 = unlimited
greenlight  in  1  async light detector input
yellowlight  in  1  async light detector input
redlight  in  1  async light detector input
flsensor_cm  in  9  front-left range, cm
frsensor_cm  in  9  front-right range, cm
encoder_cm  in  32  distance since last encoder reset, cm
drive_speed  out  7  motor speed %
reverse  out  1  motor direction
encoder_reset  out  1  one-cycle encoder clear pulse
done  out  1  one-cycle pulse when a distance-limited move ends
state  out  3  current FSM state code

Behaviour:
- Reset: FSM=IDLE, drive_speed=0, reverse=0, encoder_reset=0, done=0, cmd_ready=1, latched command=0, ramp counter=0, light synchronisers=0.
- Lights: each passes through a 2-flop synchroniser before use; all use is 2 cycles late.
- Ceiling, in priority order:
  - red → 0
  - obstacle (reverse=0 and min(fl,fr) < STOP_CM) → 0
  - yellow → min(cmd_speed, YELLOW_PCT)
  - otherwise → cmd_speed
  - green has no effect beyond clearing red/yellow.
- Ramp:
  - Free-running counter 0..RAMP_DIV-1; tick on the cycle it equals RAMP_DIV-1.
  - On a tick, drive_speed moves 1 toward its target; no change between ticks.
  - Target = ceiling in ACCEPT/RUN and 0 in BRAKE.
- States (code):
  - IDLE(0): cmd_ready=1, target 0. On accept → ACCEPT.
  - ACCEPT(1): latch cmd, set reverse=cmd_reverse, encoder_reset=1 for this cycle → RUN.
  - RUN(2): cmd_ready=1.
    - Accept with same direction → ACCEPT (speed continues from current value).
    - Accept with opposite direction → latch cmd, → BRAKE with flip pending.
    - If cmd_dist_cm≠0 and encoder_cm ≥ cmd_dist_cm → BRAKE with completion pending. Comparison suppressed in the first cycle after ACCEPT.
  - BRAKE(3): cmd_ready=0, ramp down. When drive_speed==0 → DWELL.
  - DWELL(4): cmd_ready=0, speed 0, count DIR_WAIT cycles, then:
    - flip pending → ACCEPT
    - completion pending → IDLE with done=1 for one cycle.
- Simultaneous distance-reached and opposite-direction accept in RUN: the accept wins and completion is discarded.
- A cmd_speed=0 command is legal: RUN holds at 0 and distance is never reached unless the encoder moves.
- reverse never changes while drive_speed≠0.
- Reset asserted mid-move: immediate return to reset values, with no ramp down.

Optional Feature:
ESTOP_EN
- Defined: when the ceiling is 0 due to red or obstacle, drive_speed is forced to 0 on the next cycle, without waiting for ramp ticks. The ramp then resumes from 0 once the condition clears.
- Undefined: red/obstacle slow down at the normal ramp rate.

Test Plan:
- RAMP_DIV=4, no lights, accept speed 10 fwd dist 0 → encoder_reset pulse 1 cycle after accept; drive_speed +1 every 4 cycles, reaching 10 after 40 cycles, then holds.
- Running at 50, assert yellowlight → 2 cycles later target=30; speed 49..30 one step per tick; deassert → ramps back to 50.
- Running fwd at 20, accept reverse 20 → BRAKE to 0, DWELL for DIR_WAIT=8 cycles, reverse=1, encoder_reset pulse, ramp to 20; reverse never toggles with speed≠0.
- Accept fwd speed 5 dist 100, drive encoder_cm 0→100 → on 100, BRAKE to 0, DWELL, done pulse 1 cycle, state=IDLE, cmd_ready=1.
- Running fwd at 40, set flsensor_cm=15 → ramp to 0 (ESTOP_EN: 0 next cycle); same sensors while reverse=1 → no effect.
- Assert reset_reset mid-BRAKE at speed 12 → drive_speed=0, reverse=0, state=0 asynchronously.
